alu_exec_ctrl: RTL and testbench

- Execute-stage sequencer that sits directly upstream and downstream of the combinational ALU.
- Accepts one decoded instruction via a valid/ready handshake and reads both operands from an internal 16x16 register file.
- Drives the ALU operand and opcode inputs, captures the ALU result and its five flags, writes the result back to Rdest, and updates the processor status register (PSR).
- Single issue: one instruction in flight.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/regfile_16x16.sv | 39 +++
 rtl/alu_exec_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag, state and flag-mask definitions for the execute stage
package alu_pkg;

  localparam int NREGS = 16;
  localparam int WIDTH = 16;
  localparam int IDXW  = $clog2(NREGS);

  // Opcode encoding shared with the combinational ALU
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_ADDI   = 5'd1;
  localparam logic [4:0] OP_ADDU   = 5'd2;
  localparam logic [4:0] OP_ADDUI  = 5'd3;
  localparam logic [4:0] OP_ADDC   = 5'd4;
  localparam logic [4:0] OP_ADDCU  = 5'd5;
  localparam logic [4:0] OP_ADDCUI = 5'd6;
  localparam logic [4:0] OP_ADDCI  = 5'd7;
  localparam logic [4:0] OP_SUB    = 5'd8;
  localparam logic [4:0] OP_SUBI   = 5'd9;
  localparam logic [4:0] OP_CMP    = 5'd10;
  localparam logic [4:0] OP_CMPI   = 5'd11;
  localparam logic [4:0] OP_CMPUI  = 5'd12;
  localparam logic [4:0] OP_AND    = 5'd13;
  localparam logic [4:0] OP_OR     = 5'd14;
  localparam logic [4:0] OP_XOR    = 5'd15;
  localparam logic [4:0] OP_NOT    = 5'd16;
  localparam logic [4:0] OP_LSH    = 5'd17;
  localparam logic [4:0] OP_LSHI   = 5'd18;
  localparam logic [4:0] OP_RSH    = 5'd19;
  localparam logic [4:0] OP_RSHI   = 5'd20;
  localparam logic [4:0] OP_ALSH   = 5'd21;
  localparam logic [4:0] OP_ARSH   = 5'd22;
  localparam logic [4:0] OP_NOP    = 5'd23;

  // Flag bit positions within {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Which PSR bits an opcode is allowed to change
  function automatic logic [4:0] flag_mask(input logic [4:0] op);
    logic [4:0] m;
    m = 5'b00000;
    case (op)
      OP_ADD, OP_ADDI, OP_ADDU, OP_ADDUI, OP_ADDC, OP_ADDCU, OP_ADDCUI, OP_ADDCI,
      OP_SUB, OP_SUBI: begin
        m[FLAG_C] = 1'b1;
        m[FLAG_F] = 1'b1;
      end
      OP_CMP, OP_CMPI, OP_CMPUI: begin
        m[FLAG_L] = 1'b1;
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/regfile_16x16.sv
// rtl/regfile_16x16.sv - register file with two operand read ports, a debug read port and one write port
module regfile_16x16 #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  output logic [WIDTH-1:0]         rdata_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [WIDTH-1:0]         rdata_b,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  logic [WIDTH-1:0] mem [NREGS];

  // Clear every entry on reset, otherwise write one entry per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads are combinational, so a same-cycle write is only seen after the edge
  always_comb begin
    rdata_a  = mem[raddr_a];
    rdata_b  = mem[raddr_b];
    dbg_data = mem[dbg_addr];
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - single-issue execute sequencer wrapping operand fetch, ALU drive and writeback
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [4:0]               InOp,
  input  logic [$clog2(NREGS)-1:0] InDest,
  input  logic [$clog2(NREGS)-1:0] InSrc,
  input  logic [7:0]               InImm,
  output logic [WIDTH-1:0]         AluA,
  output logic [WIDTH-1:0]         AluB,
  output logic [4:0]               AluOp,
  output logic                     AluCin,
  input  logic [WIDTH-1:0]         AluOut,
  input  logic [4:0]               AluFlags,
  output logic [4:0]               Psr,
  output logic                     Done,
  output logic                     IllegalOp,
  input  logic [$clog2(NREGS)-1:0] DbgAddr,
  output logic [WIDTH-1:0]         DbgData
);

  localparam int AW = $clog2(NREGS);

  state_t           state, state_nxt;
  logic [4:0]       op_q;
  logic [AW-1:0]    dest_q;
  logic [7:0]       imm_q;
  logic [WIDTH-1:0] rs_q, rd_q, res_q;
  logic [4:0]       flags_q, psr_q;
  logic [WIDTH-1:0] rf_src, rf_dest;
  logic             accept, illegal, wb_en;
  logic [4:0]       mask;

  assign accept  = InValid && (state == IDLE);
  assign illegal = (op_q > OP_NOP);
  assign mask    = illegal ? 5'b00000 : flag_mask(op_q);
  assign wb_en   = (state == WB) && !illegal &&
                   (op_q != OP_CMP) && (op_q != OP_CMPI) &&
                   (op_q != OP_CMPUI) && (op_q != OP_NOP);
  assign Psr     = psr_q;

  regfile_16x16 #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rf (
    .clk      (clk),
    .rst_n    (reset_n),
    .we       (wb_en),
    .waddr    (dest_q),
    .wdata    (res_q),
    .raddr_a  (InSrc),
    .rdata_a  (rf_src),
    .raddr_b  (InDest),
    .rdata_b  (rf_dest),
    .dbg_addr (DbgAddr),
    .dbg_data (DbgData)
  );

  // FSM state register; reset mid-instruction simply drops it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and handshake/status outputs
  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    Done      = 1'b0;
    IllegalOp = 1'b0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        Done      = 1'b1;
        IllegalOp = illegal;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the instruction and both pre-instruction operands at accept, the ALU result in EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_NOP;
      dest_q  <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= InOp;
        dest_q <= InDest;
        imm_q  <= InImm;
        rs_q   <= rf_src;
        rd_q   <= rf_dest;
      end
      if (state == EXEC) begin
        res_q   <= AluOut;
        flags_q <= AluFlags;
      end
    end
  end

  // Merge ALU flags into the PSR only on the bits this opcode owns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          psr_q <= '0;
    else if (state == WB)  psr_q <= (psr_q & ~mask) | (flags_q & mask);
  end

  // ALU inputs are only meaningful in EXEC; elsewhere the ALU sees a NOP
  always_comb begin
    AluA   = '0;
    AluB   = '0;
    AluOp  = OP_NOP;
    AluCin = 1'b0;
    if (state == EXEC) begin
      AluB  = rd_q;
      AluOp = illegal ? OP_NOP : op_q;
      case (op_q)
        OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: AluA = {{(WIDTH-8){imm_q[7]}}, imm_q};
        OP_ADDUI, OP_ADDCUI, OP_CMPUI:      AluA = {{(WIDTH-8){1'b0}}, imm_q};
        OP_LSHI, OP_RSHI:                   AluA = {{(WIDTH-4){1'b0}}, imm_q[3:0]};
        default:                            AluA = rs_q;
      endcase
      if ((op_q == OP_ADDC) || (op_q == OP_ADDCU) ||
          (op_q == OP_ADDCUI) || (op_q == OP_ADDCI)) begin
        AluCin = psr_q[FLAG_C];
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed scoreboard bench for the execute sequencer with a reference ALU
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InOp;
  logic [3:0]  InDest, InSrc;
  logic [7:0]  InImm;
  logic [15:0] AluA, AluB;
  logic [4:0]  AluOp;
  logic        AluCin;
  logic [15:0] AluOut;
  logic [4:0]  AluFlags;
  logic [4:0]  Psr;
  logic        Done, IllegalOp;
  logic [3:0]  DbgAddr;
  logic [15:0] DbgData;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  dest;
    logic [15:0] pre;
    logic [15:0] post;
    logic [4:0]  psr;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mrf [16];
  logic [4:0]  mpsr;
  logic [15:0] e_a, e_b;
  logic [4:0]  e_op;
  logic        e_cin;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
    .InOp(InOp), .InDest(InDest), .InSrc(InSrc), .InImm(InImm),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluCin(AluCin),
    .AluOut(AluOut), .AluFlags(AluFlags), .Psr(Psr), .Done(Done),
    .IllegalOp(IllegalOp), .DbgAddr(DbgAddr), .DbgData(DbgData)
  );

  // Reference ALU: returns {C,L,F,Z,N, result}; A is the Rsrc operand, B is Rdest
  function automatic logic [20:0] ref_alu(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  f;
    r = b;
    f = 5'b0;
    if (op <= 5'd7) begin
      s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      r = s[15:0];
      f[4] = s[16];
      f[2] = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      case (op)
        OP_SUB, OP_SUBI: begin
          r = b - a;
          f[4] = (a > b);
          f[2] = (a[15] != b[15]) && (r[15] != b[15]);
        end
        OP_CMP, OP_CMPI, OP_CMPUI: begin
          f[3] = (a > b);
          f[1] = (a == b);
          f[0] = ($signed(a) > $signed(b));
        end
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_XOR: r = a ^ b;
        OP_NOT: r = ~a;
        OP_LSH, OP_LSHI, OP_ALSH: r = b << a[3:0];
        OP_RSH, OP_RSHI: r = b >> a[3:0];
        OP_ARSH: r = $signed(b) >>> a[3:0];
        default: r = b;
      endcase
    end
    return {f, r};
  endfunction

  always_comb begin
    {AluFlags, AluOut} = ref_alu(AluOp, AluA, AluB, AluCin);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict operands, result and PSR for one instruction and queue the expectation
  task automatic push_exp(input logic [4:0] op, input logic [3:0] dest,
                          input logic [3:0] src, input logic [7:0] imm);
    exp_t e;
    logic [15:0] a;
    logic [20:0] r;
    logic        ill, wr, cin;
    logic [4:0]  m;
    ill = (op > 5'd23);
    case (op)
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: a = {{8{imm[7]}}, imm};
      OP_ADDUI, OP_ADDCUI, OP_CMPUI:      a = {8'h00, imm};
      OP_LSHI, OP_RSHI:                   a = {12'h000, imm[3:0]};
      default:                            a = mrf[src];
    endcase
    cin = (op == OP_ADDC || op == OP_ADDCU || op == OP_ADDCUI || op == OP_ADDCI) ? mpsr[4] : 1'b0;
    r = ref_alu(ill ? OP_NOP : op, a, mrf[dest], cin);
    if (ill) m = 5'b00000;
    else if (op <= 5'd9) m = 5'b10100;
    else if (op <= 5'd12) m = 5'b01011;
    else m = 5'b00000;
    wr = !ill && !(op inside {OP_CMP, OP_CMPI, OP_CMPUI, OP_NOP});
    e.dest = dest;
    e.pre  = mrf[dest];
    e.post = wr ? r[15:0] : mrf[dest];
    mpsr   = (mpsr & ~m) | (r[20:16] & m);
    e.psr  = mpsr;
    e.ill  = ill;
    mrf[dest] = e.post;
    e_a = a; e_b = e.pre; e_op = ill ? OP_NOP : op; e_cin = cin;
    sb.push_back(e);
  endtask

  task automatic check_exec(input string tag);
    chk({tag, "/alua"}, AluA, e_a);
    chk({tag, "/alub"}, AluB, e_b);
    chk({tag, "/aluop"}, {11'b0, AluOp}, {11'b0, e_op});
    chk({tag, "/alucin"}, {15'b0, AluCin}, {15'b0, e_cin});
    chk({tag, "/busy"}, {15'b0, InReady}, 16'd0);
  endtask

  // Wait (bounded) for Done, then pop and compare against the scoreboard head
  task automatic finish_wb(input string tag);
    exp_t e;
    int n;
    DbgAddr = sb[0].dest;
    #1;
    n = 0;
    while (!Done && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/done"}, {15'b0, Done}, 16'd1);
    e = sb.pop_front();
    chk({tag, "/illegal"}, {15'b0, IllegalOp}, {15'b0, e.ill});
    chk({tag, "/prewrite"}, DbgData, e.pre);
    @(negedge clk);
    chk({tag, "/rf"}, DbgData, e.post);
    chk({tag, "/psr"}, {11'b0, Psr}, {11'b0, e.psr});
    chk({tag, "/done_clr"}, {15'b0, Done}, 16'd0);
    chk({tag, "/ready"}, {15'b0, InReady}, 16'd1);
  endtask

  task automatic issue(input string tag, input logic [4:0] op, input logic [3:0] dest,
                       input logic [3:0] src, input logic [7:0] imm);
    @(negedge clk);
    InValid = 1'b1; InOp = op; InDest = dest; InSrc = src; InImm = imm;
    chk({tag, "/ready_in"}, {15'b0, InReady}, 16'd1);
    push_exp(op, dest, src, imm);
    @(negedge clk);
    InValid = 1'b0;
    check_exec(tag);
    finish_wb(tag);
  endtask

  initial begin
    logic seen_done;
    reset_n = 1'b0; InValid = 1'b0; InOp = 5'd0; InDest = 4'd0; InSrc = 4'd0;
    InImm = 8'd0; DbgAddr = 4'd0;
    for (int i = 0; i < 16; i++) mrf[i] = 16'h0000;
    mpsr = 5'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset/ready", {15'b0, InReady}, 16'd1);
    chk("reset/done", {15'b0, Done}, 16'd0);
    chk("reset/illegal", {15'b0, IllegalOp}, 16'd0);
    chk("reset/aluop", {11'b0, AluOp}, {11'b0, OP_NOP});
    chk("reset/psr", {11'b0, Psr}, 16'd0);
    chk("reset/r0", DbgData, 16'h0000);
    reset_n = 1'b1;

    issue("addi_r1", OP_ADDI, 4'd1, 4'd0, 8'h7F);
    issue("load_r2", OP_ADDI, 4'd2, 4'd0, 8'hFF);
    issue("rshi_r2", OP_RSHI, 4'd2, 4'd0, 8'h01);
    issue("add_r2r2", OP_ADD, 4'd2, 4'd2, 8'h00);
    issue("load_r3", OP_ADDI, 4'd3, 4'd0, 8'h05);
    issue("cmpi_r3", OP_CMPI, 4'd3, 4'd0, 8'h05);
    issue("load_r6", OP_ADDI, 4'd6, 4'd0, 8'hFF);
    issue("load_r7", OP_ADDI, 4'd7, 4'd0, 8'h01);
    issue("add_carry", OP_ADD, 4'd6, 4'd7, 8'h00);
    issue("addc_r4", OP_ADDC, 4'd4, 4'd5, 8'h00);
    issue("addui_r10", OP_ADDUI, 4'd10, 4'd0, 8'h80);
    issue("subi_r10", OP_SUBI, 4'd10, 4'd0, 8'h01);
    issue("lshi_r10", OP_LSHI, 4'd10, 4'd0, 8'h13);
    issue("illegal", 5'd31, 4'd1, 4'd2, 8'h00);

    // Reset while an instruction sits in EXEC
    @(negedge clk);
    InValid = 1'b1; InOp = OP_ADDI; InDest = 4'd9; InSrc = 4'd0; InImm = 8'h11;
    @(negedge clk);
    InValid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort/ready", {15'b0, InReady}, 16'd1);
    chk("abort/done", {15'b0, Done}, 16'd0);
    chk("abort/aluop", {11'b0, AluOp}, {11'b0, OP_NOP});
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_done = seen_done | Done;
    end
    chk("abort/no_done", {15'b0, seen_done}, 16'd0);
    DbgAddr = 4'd9; #1;
    chk("abort/r9", DbgData, 16'h0000);
    DbgAddr = 4'd1; #1;
    chk("abort/r1_cleared", DbgData, 16'h0000);
    chk("abort/psr", {11'b0, Psr}, 16'd0);
    for (int i = 0; i < 16; i++) mrf[i] = 16'h0000;
    mpsr = 5'b0;

    // InValid held high: the second instruction may only be taken in cycle 3
    @(negedge clk);
    InValid = 1'b1; InOp = OP_ADDI; InDest = 4'd8; InSrc = 4'd0; InImm = 8'h01;
    chk("b2b/ready_a", {15'b0, InReady}, 16'd1);
    push_exp(OP_ADDI, 4'd8, 4'd0, 8'h01);
    @(negedge clk);
    check_exec("b2b_a");
    InOp = OP_ADDI; InDest = 4'd8; InSrc = 4'd0; InImm = 8'h02;
    @(negedge clk);
    finish_wb("b2b_a");
    push_exp(OP_ADDI, 4'd8, 4'd0, 8'h02);
    @(negedge clk);
    InValid = 1'b0;
    check_exec("b2b_b");
    finish_wb("b2b_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
